// File: rtl/nettlp_cmd_rx_if.sv
// nettlp_cmd_rx_if: command types plus the AXI-Stream payload / command FIFO bundle
// Ports: s_axis_* payload stream (tvalid/tready/tdata/tkeep/tlast),
//        fifo_cmd_o_* command FIFO write side (wr_en/full/din).
//        slave = receiver view, master = source/FIFO view.
package nettlp_cmd_pkg;
    localparam logic [7:0] NETTLP_OPC_REG_RD = 8'h01;
    localparam logic [7:0] NETTLP_OPC_REG_WR = 8'h02;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] dwaddr;
        logic [31:0] data;
    } FIFO_NETTLP_CMD_T;
endpackage

interface nettlp_cmd_rx_if;
    import nettlp_cmd_pkg::*;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [63:0]      s_axis_tdata;
    logic [7:0]       s_axis_tkeep;
    logic             s_axis_tlast;
    logic             fifo_cmd_o_wr_en;
    logic             fifo_cmd_o_full;
    FIFO_NETTLP_CMD_T fifo_cmd_o_din;
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, fifo_cmd_o_full,
        output s_axis_tready, fifo_cmd_o_wr_en, fifo_cmd_o_din
    );
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, fifo_cmd_o_full,
        input  s_axis_tready, fifo_cmd_o_wr_en, fifo_cmd_o_din
    );
endinterface

// File: rtl/nettlp_cmd_rx.sv
// nettlp_cmd_rx: parse NetTLP command packets from a 64-bit stream into a command FIFO
// Ports: clk, rst (sync, active-high); s = payload stream in / command FIFO out;
//        stat_pkt_cnt / stat_cmd_cnt / stat_err_cnt = good packets, commands written, errors.
module nettlp_cmd_rx #(
    parameter int MAX_CMDS = 64
) (
    input  logic               clk,
    input  logic               rst,
    nettlp_cmd_rx_if.slave     s,
    output logic [15:0]        stat_pkt_cnt,
    output logic [15:0]        stat_cmd_cnt,
    output logic [15:0]        stat_err_cnt
);
    import nettlp_cmd_pkg::*;

    typedef enum logic [1:0] {HDR, CMD, DROP} state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_CMDS);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_rem, w_rem_nxt;
    logic        w_pkt_inc, w_err_inc, w_acc, w_cmd_ok;
    logic [15:0] w_n;
    logic [7:0]  w_opc;

    assign w_n   = {s.s_axis_tdata[7:0], s.s_axis_tdata[15:8]};
    assign w_opc = s.s_axis_tdata[7:0];
    assign w_cmd_ok = (w_opc == NETTLP_OPC_REG_RD || w_opc == NETTLP_OPC_REG_WR) && s.s_axis_tkeep == 8'hFF;

    // tready is held low in the reset cycle, so nothing is accepted or written then;
    // in CMD it follows the FIFO, which also keeps wr_en off while full.
    assign s.s_axis_tready    = rst ? 1'b0 : (r_state == CMD ? !s.fifo_cmd_o_full : 1'b1);
    assign w_acc              = s.s_axis_tvalid && s.s_axis_tready;
    assign s.fifo_cmd_o_wr_en = w_acc && r_state == CMD && w_cmd_ok;
    assign s.fifo_cmd_o_din   = rst ? '0 : {w_opc, s.s_axis_tdata[23:16], s.s_axis_tdata[31:24],
                                s.s_axis_tdata[39:32], s.s_axis_tdata[47:40],
                                s.s_axis_tdata[55:48], s.s_axis_tdata[63:56]};

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_pkt_inc   = 1'b0;
        w_err_inc   = 1'b0;
        if (w_acc) begin
            case (r_state)
                HDR: begin
                    if (s.s_axis_tlast) begin
                        w_pkt_inc = w_n == 16'd0;
                        w_err_inc = w_n != 16'd0;
                    end else if (w_n == 16'd0 || w_n > MAX_N) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = DROP;
                    end else begin
                        w_rem_nxt   = w_n;
                        w_state_nxt = CMD;
                    end
                end
                CMD: begin
                    // a bad command and a framing error on the same beat count once
                    w_rem_nxt = r_rem - 16'd1;
                    w_err_inc = !w_cmd_ok;
                    if (r_rem == 16'd1) begin
                        w_pkt_inc   = s.s_axis_tlast;
                        w_err_inc   = !w_cmd_ok || !s.s_axis_tlast;
                        w_state_nxt = s.s_axis_tlast ? HDR : DROP;
                    end else if (s.s_axis_tlast) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = HDR;
                    end
                end
                default: w_state_nxt = s.s_axis_tlast ? HDR : DROP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HDR;
            r_rem        <= '0;
            stat_pkt_cnt <= '0;
            stat_cmd_cnt <= '0;
            stat_err_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rem        <= w_rem_nxt;
            stat_pkt_cnt <= stat_pkt_cnt + {15'd0, w_pkt_inc};
            stat_cmd_cnt <= stat_cmd_cnt + {15'd0, s.fifo_cmd_o_wr_en};
            stat_err_cnt <= stat_err_cnt + {15'd0, w_err_inc};
        end
    end
endmodule

// File: tb/tb_nettlp_cmd_rx.sv
// tb_nettlp_cmd_rx: directed checks of nettlp_cmd_rx packet parsing, stalls, errors and reset
module tb_nettlp_cmd_rx;
    import nettlp_cmd_pkg::*;

    logic        clk, rst;
    logic [15:0] pkt_cnt, cmd_cnt, err_cnt;
    int          n_chk, n_fail, viol, low_cnt, n_before;
    logic [55:0] got_q[$], exp_q[$];
    logic [55:0] last_din;

    nettlp_cmd_rx_if ax();

    nettlp_cmd_rx #(.MAX_CMDS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (ax),
        .stat_pkt_cnt (pkt_cnt),
        .stat_cmd_cnt (cmd_cnt),
        .stat_err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ax.fifo_cmd_o_wr_en) begin
            got_q.push_back(ax.fifo_cmd_o_din);
            last_din = ax.fifo_cmd_o_din;
            if (ax.fifo_cmd_o_full) viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [15:0] n);
        return {48'd0, n[7:0], n[15:8]};
    endfunction

    function automatic logic [63:0] cw(input logic [7:0] opc, input logic [15:0] a, input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24], a[7:0], a[15:8], 8'h5A, opc};
    endfunction

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic acc;
        acc = 1'b0;
        ax.s_axis_tdata  = d;
        ax.s_axis_tkeep  = k;
        ax.s_axis_tlast  = l;
        ax.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = ax.s_axis_tvalid && ax.s_axis_tready;
            @(posedge clk);
        end
        #1;
        ax.s_axis_tvalid = 1'b0;
        if (!acc) chk("beat_timeout", 0, 1);
    endtask

    task automatic good(input logic [7:0] opc, input logic [15:0] a, input logic [31:0] d, input logic l);
        exp_q.push_back({opc, a, d});
        beat(cw(opc, a, d), 8'hFF, l);
    endtask

    task automatic stats(input string tag, input logic [15:0] p, input logic [15:0] c, input logic [15:0] e);
        chk({tag, "_pkt"}, pkt_cnt, p);
        chk({tag, "_cmd"}, cmd_cnt, c);
        chk({tag, "_err"}, err_cnt, e);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; viol = 0;
        rst = 1'b1;
        ax.s_axis_tvalid = 1'b0; ax.s_axis_tdata = '0; ax.s_axis_tkeep = '0;
        ax.s_axis_tlast = 1'b0; ax.fifo_cmd_o_full = 1'b0;
        @(negedge clk);
        chk("rst_tready", ax.s_axis_tready, 0);
        chk("rst_wr_en", ax.fifo_cmd_o_wr_en, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("hdr_tready", ax.s_axis_tready, 1);
        stats("reset", 0, 0, 0);

        beat(hdr(2), 8'hFF, 0);
        good(NETTLP_OPC_REG_RD, 16'h0001, 32'h11223344, 0);
        good(NETTLP_OPC_REG_WR, 16'h0005, 32'hC0A80A03, 1);
        chk("s1_data", last_din[31:0], 32'hC0A80A03);
        chk("s1_addr", last_din[47:32], 16'h0005);
        stats("s1", 1, 2, 0);

        beat(hdr(3), 8'hFF, 0);
        good(NETTLP_OPC_REG_WR, 16'h0010, 32'hAAAA0001, 0);
        exp_q.push_back({NETTLP_OPC_REG_RD, 16'h0011, 32'hBBBB0002});
        ax.s_axis_tdata = cw(NETTLP_OPC_REG_RD, 16'h0011, 32'hBBBB0002);
        ax.s_axis_tkeep = 8'hFF; ax.s_axis_tlast = 1'b0;
        ax.s_axis_tvalid = 1'b1; ax.fifo_cmd_o_full = 1'b1;
        low_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (!ax.s_axis_tready) low_cnt++;
            @(posedge clk);
        end
        #1 ax.fifo_cmd_o_full = 1'b0;
        @(negedge clk);
        chk("s2_tready_back", ax.s_axis_tready, 1);
        @(posedge clk); #1;
        ax.s_axis_tvalid = 1'b0;
        good(NETTLP_OPC_REG_WR, 16'h0012, 32'hCCCC0003, 1);
        chk("s2_stall_cycles", low_cnt, 5);
        stats("s2", 2, 5, 0);

        beat(hdr(2), 8'hFF, 0);
        good(NETTLP_OPC_REG_RD, 16'h0020, 32'h00000020, 1);
        stats("s3_short", 2, 6, 1);
        beat(hdr(1), 8'hFF, 0);
        good(NETTLP_OPC_REG_RD, 16'h0021, 32'h00000021, 1);
        stats("s3_next", 3, 7, 1);

        beat(hdr(1), 8'hFF, 0);
        good(NETTLP_OPC_REG_WR, 16'h0030, 32'h00000030, 0);
        for (int i = 0; i < 3; i++) beat(cw(NETTLP_OPC_REG_RD, 16'h0031, 32'h0), 8'hFF, i == 2);
        stats("s4_drop", 3, 8, 2);
        beat(hdr(0), 8'hFF, 1);
        stats("s4_next", 4, 8, 2);

        beat(hdr(65), 8'hFF, 0);
        for (int i = 0; i < 3; i++) beat(cw(NETTLP_OPC_REG_RD, 16'h0040, 32'h0), 8'hFF, i == 2);
        stats("s5_over", 4, 8, 3);
        beat(hdr(1), 8'hFF, 0);
        beat(cw(8'hEE, 16'h0041, 32'h1), 8'hFF, 1);
        stats("s5_badopc", 5, 8, 4);
        beat(hdr(1), 8'hFF, 0);
        beat(cw(NETTLP_OPC_REG_RD, 16'h0042, 32'h2), 8'h0F, 1);
        stats("s5_keep", 6, 8, 5);
        beat(hdr(1), 8'hFF, 1);
        stats("s5_hdrlast", 6, 8, 6);
        beat(hdr(1), 8'hFF, 0);
        beat(cw(8'hEE, 16'h0043, 32'h3), 8'hFF, 0);
        beat(cw(NETTLP_OPC_REG_RD, 16'h0044, 32'h4), 8'hFF, 1);
        stats("s5_double", 6, 8, 7);
        beat(hdr(0), 8'hFF, 0);
        beat(cw(NETTLP_OPC_REG_RD, 16'h0045, 32'h5), 8'hFF, 1);
        stats("s5_zero", 6, 8, 8);
        beat(hdr(64), 8'hFF, 0);
        for (int i = 0; i < 64; i++) good(NETTLP_OPC_REG_RD, 16'(i), 32'(i * 3), i == 63);
        stats("s5_max", 7, 72, 8);

        chk("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk($sformatf("wr_%0d", i), got_q[i], exp_q[i]);
        chk("full_violation", viol, 0);

        beat(hdr(4), 8'hFF, 0);
        n_before = got_q.size();
        ax.s_axis_tdata = cw(NETTLP_OPC_REG_RD, 16'h0050, 32'h50);
        ax.s_axis_tkeep = 8'hFF; ax.s_axis_tlast = 1'b0; ax.s_axis_tvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tready", ax.s_axis_tready, 0);
        chk("midrst_wr_en", ax.fifo_cmd_o_wr_en, 0);
        chk("midrst_din", ax.fifo_cmd_o_din, 0);
        @(posedge clk); #1;
        rst = 1'b0; ax.s_axis_tvalid = 1'b0;
        stats("midrst", 0, 0, 0);
        chk("midrst_nowrite", got_q.size(), n_before);
        beat(hdr(0), 8'hFF, 1);
        stats("after_rst", 1, 0, 0);

        for (int i = 0; i < 65535; i++) beat(hdr(1), 8'hFF, 1);
        chk("err_max", err_cnt, 16'hFFFF);
        beat(hdr(1), 8'hFF, 1);
        stats("err_wrap", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
